// File: rtl/serial_tx_ctrl.sv
// serial_tx_ctrl: pulls words from a FIFO read port and sends each one as a
// serial frame (payload bits, optional parity bit, then GAP idle bit-times).
// Optional feature: define SERIAL_TX_PARITY_EN to append an even-parity bit.
module serial_tx_ctrl #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned GAP       = 1,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic              clk_out,
  input  logic              rst,
  input  logic              empty,
  input  logic              rden,
  input  logic [DATA_W-1:0] rddata,
  input  logic              sync_flush,
  input  logic              tx_en,
  output logic              remove,
  output logic              ser_out,
  output logic              ser_valid,
  output logic              frame_start,
  output logic              busy,
  output logic              rd_timeout
);

  localparam int unsigned CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int unsigned GAP_W = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [CNT_W-1:0] BIT_LOAD = CNT_W'(DATA_W - 1);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((GAP > 0) ? GAP - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_SHIFT,
`ifdef SERIAL_TX_PARITY_EN
    S_PAR,
`endif
    S_GAP
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] shreg;
  logic [DATA_W-1:0] shift_next;
  logic [CNT_W-1:0]  bit_cnt;
  logic [GAP_W-1:0]  gap_cnt;
  logic [1:0]        wait_cnt;
`ifdef SERIAL_TX_PARITY_EN
  logic              par_bit;
`endif

  // Shift register contents after the current bit has been consumed
  always_comb begin
    shift_next = MSB_FIRST ? (shreg << 1) : (shreg >> 1);
  end

  // Frame sequencer; every output is a register set on the transition into
  // the state it belongs to, so each output lines up with its state cycle.
  always_ff @(posedge clk_out) begin
    if (!rst || sync_flush) begin
      state       <= S_IDLE;
      remove      <= 1'b0;
      ser_out     <= 1'b1;
      ser_valid   <= 1'b0;
      frame_start <= 1'b0;
      busy        <= 1'b0;
      rd_timeout  <= 1'b0;
      shreg       <= '0;
      bit_cnt     <= '0;
      gap_cnt     <= '0;
      wait_cnt    <= '0;
`ifdef SERIAL_TX_PARITY_EN
      par_bit     <= 1'b0;
`endif
    end else begin
      remove      <= 1'b0;
      frame_start <= 1'b0;
      rd_timeout  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (tx_en && !empty) begin
            state  <= S_REQ;
            remove <= 1'b1;
            busy   <= 1'b1;
          end
        end
        S_REQ: begin
          state    <= S_WAIT;
          wait_cnt <= '0;
        end
        S_WAIT: begin
          // The timeout pulse is registered, so it is raised at the end of the
          // second WAIT cycle and the third cycle only returns to IDLE; a
          // strobe arriving in that third cycle is ignored.
          if (rd_timeout) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else if (rden) begin
            state       <= S_SHIFT;
            shreg       <= rddata;
            bit_cnt     <= BIT_LOAD;
            ser_out     <= MSB_FIRST ? rddata[DATA_W-1] : rddata[0];
            ser_valid   <= 1'b1;
            frame_start <= 1'b1;
`ifdef SERIAL_TX_PARITY_EN
            par_bit     <= ^rddata;
`endif
          end else if (wait_cnt == 2'd1) begin
            rd_timeout <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 2'd1;
          end
        end
        S_SHIFT: begin
          if (bit_cnt != '0) begin
            shreg   <= shift_next;
            ser_out <= MSB_FIRST ? shift_next[DATA_W-1] : shift_next[0];
            bit_cnt <= bit_cnt - CNT_W'(1);
          end else begin
`ifdef SERIAL_TX_PARITY_EN
            state   <= S_PAR;
            ser_out <= par_bit;
`else
            ser_out   <= 1'b1;
            ser_valid <= 1'b0;
            if (GAP > 0) begin
              state   <= S_GAP;
              gap_cnt <= GAP_LOAD;
            end else begin
              state <= S_IDLE;
              busy  <= 1'b0;
            end
`endif
          end
        end
`ifdef SERIAL_TX_PARITY_EN
        S_PAR: begin
          ser_out   <= 1'b1;
          ser_valid <= 1'b0;
          if (GAP > 0) begin
            state   <= S_GAP;
            gap_cnt <= GAP_LOAD;
          end else begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        end
`endif
        S_GAP: begin
          if (gap_cnt == '0) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else begin
            gap_cnt <= gap_cnt - GAP_W'(1);
          end
        end
        default: begin
          state     <= S_IDLE;
          busy      <= 1'b0;
          ser_out   <= 1'b1;
          ser_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_tx_ctrl.sv
// Self-checking bench for serial_tx_ctrl: a FIFO read-side model answers each
// remove with rden one cycle later; observed serial bits and pulse timings are
// compared against frames computed from the pushed words.
module tb_serial_tx_ctrl;

  localparam int DATA_W    = 8;
  localparam int GAP       = 1;
  localparam int MSB_FIRST = 1;
`ifdef SERIAL_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int PERIOD = DATA_W + GAP + 3 + PAR;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              empty = 1'b1;
  logic              rden = 1'b0;
  logic [DATA_W-1:0] rddata = '0;
  logic              sync_flush = 1'b0;
  logic              tx_en = 1'b0;
  logic              remove, ser_out, ser_valid, frame_start, busy, rd_timeout;

  int checks = 0;
  int errors = 0;

  int                cyc = 0;
  logic [DATA_W-1:0] fifo[$];
  logic [DATA_W-1:0] pend_word;
  bit                pend_valid = 0;
  bit                drop_reads = 0;
  int                underflow = 0;
  int                bad_remove = 0;

  bit obs_bits[$];
  bit exp_bits[$];
  int val_cyc[$];
  int fs_cyc[$];
  int to_cyc[$];
  int rm_cyc[$];
  bit busy_hist[int];

  serial_tx_ctrl #(
    .DATA_W   (DATA_W),
    .GAP      (GAP),
    .MSB_FIRST(MSB_FIRST)
  ) dut (
    .clk_out    (clk),
    .rst        (rst),
    .empty      (empty),
    .rden       (rden),
    .rddata     (rddata),
    .sync_flush (sync_flush),
    .tx_en      (tx_en),
    .remove     (remove),
    .ser_out    (ser_out),
    .ser_valid  (ser_valid),
    .frame_start(frame_start),
    .busy       (busy),
    .rd_timeout (rd_timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  // Advance one cycle, record outputs, and run the FIFO read-side model.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    busy_hist[cyc] = busy;
    if (ser_valid) begin
      obs_bits.push_back(ser_out);
      val_cyc.push_back(cyc);
    end
    if (frame_start) fs_cyc.push_back(cyc);
    if (rd_timeout) to_cyc.push_back(cyc);
    if (remove) rm_cyc.push_back(cyc);
    if (remove && (!busy || ser_valid)) bad_remove++;
    rden   = 1'b0;
    rddata = DATA_W'($urandom);
    if (pend_valid) begin
      rden       = !drop_reads;
      rddata     = pend_word;
      pend_valid = 0;
    end
    if (remove && rst) begin
      if (fifo.size() > 0) begin
        pend_word  = fifo.pop_front();
        pend_valid = 1;
      end else begin
        underflow++;
      end
    end
    empty = (fifo.size() == 0);
  endtask

  task automatic push_word(input logic [DATA_W-1:0] w);
    fifo.push_back(w);
    empty = 1'b0;
  endtask

  // Reference frame: payload in configured order, then parity if compiled in.
  function automatic void add_exp(input logic [DATA_W-1:0] w);
    int v = int'(w);
    for (int i = 0; i < DATA_W; i++) begin
      int pos = MSB_FIRST ? (DATA_W - 1 - i) : i;
      exp_bits.push_back(bit'((v / (1 << pos)) % 2));
    end
    if (PAR != 0) exp_bits.push_back(bit'($countones(w) % 2));
  endfunction

  function automatic int first_diff();
    int n = (obs_bits.size() < exp_bits.size()) ? obs_bits.size() : exp_bits.size();
    for (int i = 0; i < n; i++) if (obs_bits[i] != exp_bits[i]) return i;
    if (obs_bits.size() != exp_bits.size()) return n;
    return -1;
  endfunction

  function automatic void clear_obs();
    obs_bits.delete();
    exp_bits.delete();
    val_cyc.delete();
    fs_cyc.delete();
    to_cyc.delete();
    rm_cyc.delete();
  endfunction

  task automatic run_quiet(input int budget, input string name);
    int quiet = 0;
    int n = 0;
    while (quiet < 4 && n < budget) begin
      step();
      n++;
      if (!busy && !remove && !pend_valid) quiet++;
      else quiet = 0;
    end
    checks++;
    if (quiet < 4) begin
      errors++;
      $display("FAIL %s_settle: still active after %0d cycles, required idle", name, budget);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    step();
    step();
    checks++;
    if ({remove, ser_out, ser_valid, frame_start, busy, rd_timeout} !== 6'b010000) begin
      errors++;
      $display("FAIL reset_outputs: got rm/so/sv/fs/bz/to=%b, required 010000",
               {remove, ser_out, ser_valid, frame_start, busy, rd_timeout});
    end
    rst = 1'b1;
    step();
    checks++;
    if (busy !== 1'b0 || remove !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle_empty: got busy=%b remove=%b, required 0 0", busy, remove);
    end
  endtask

  task automatic test_known_word();
    logic [DATA_W-1:0] got;
    int d;
    clear_obs();
    push_word(8'hA5);
    add_exp(8'hA5);
    tx_en = 1'b1;
    run_quiet(100, "known");
    tx_en = 1'b0;
    got = '0;
    for (int i = 0; i < DATA_W && i < obs_bits.size(); i++) got[DATA_W-1-i] = obs_bits[i];
    checks++;
    if (got !== 8'hA5) begin
      errors++;
      $display("FAIL known_payload: got %h, required a5", got);
    end
    d = first_diff();
    checks++;
    if (d >= 0) begin
      errors++;
      $display("FAIL known_stream: differs at bit %0d, got %0d bits, required %0d", d, obs_bits.size(), exp_bits.size());
    end
    checks++;
    if (fs_cyc.size() != 1 || val_cyc.size() == 0 || fs_cyc[0] != val_cyc[0]) begin
      errors++;
      $display("FAIL known_frame_start: got %0d pulses, required 1 on first bit", fs_cyc.size());
    end
    checks++;
    if (val_cyc.size() != DATA_W + PAR || val_cyc[val_cyc.size()-1] - val_cyc[0] != DATA_W + PAR - 1) begin
      errors++;
      $display("FAIL known_contiguous: got %0d valid bits, required %0d consecutive", val_cyc.size(), DATA_W + PAR);
    end
    checks++;
    if (rm_cyc.size() != 1 || fs_cyc.size() == 0 || fs_cyc[0] - rm_cyc[0] != 2) begin
      errors++;
      $display("FAIL known_latency: got %0d removes, required 1 with frame_start 2 cycles later", rm_cyc.size());
    end
`ifdef SERIAL_TX_PARITY_EN
    checks++;
    if (obs_bits.size() < 9 || obs_bits[8] !== 1'b0) begin
      errors++;
      $display("FAIL parity_a5: got %0d bits, required 9th bit 0", obs_bits.size());
    end
    clear_obs();
    push_word(8'h07);
    tx_en = 1'b1;
    run_quiet(100, "parity07");
    tx_en = 1'b0;
    checks++;
    if (obs_bits.size() != 9 || obs_bits[8] !== 1'b1) begin
      errors++;
      $display("FAIL parity_07: got %0d bits, required 9 with last bit 1", obs_bits.size());
    end
`endif
  endtask

  task automatic test_back_to_back();
    int d;
    clear_obs();
    push_word(8'h01);
    push_word(8'h80);
    add_exp(8'h01);
    add_exp(8'h80);
    tx_en = 1'b1;
    run_quiet(200, "b2b");
    tx_en = 1'b0;
    checks++;
    if (fs_cyc.size() != 2 || fs_cyc[1] - fs_cyc[0] != PERIOD) begin
      errors++;
      $display("FAIL b2b_period: got %0d starts, spacing %0d, required 2 with spacing %0d",
               fs_cyc.size(), (fs_cyc.size() == 2) ? fs_cyc[1] - fs_cyc[0] : -1, PERIOD);
    end
    d = first_diff();
    checks++;
    if (d >= 0) begin
      errors++;
      $display("FAIL b2b_stream: differs at bit %0d, got %0d bits, required %0d", d, obs_bits.size(), exp_bits.size());
    end
  endtask

  task automatic test_random();
    int d;
    int bad_gap = 0;
    logic [DATA_W-1:0] w;
    clear_obs();
    for (int i = 0; i < 16; i++) begin
      w = DATA_W'($urandom);
      push_word(w);
      add_exp(w);
    end
    tx_en = 1'b1;
    run_quiet(16 * PERIOD + 100, "random");
    tx_en = 1'b0;
    d = first_diff();
    checks++;
    if (d >= 0) begin
      errors++;
      $display("FAIL random_stream: differs at bit %0d, got %0d bits, required %0d", d, obs_bits.size(), exp_bits.size());
    end
    for (int i = 1; i < fs_cyc.size(); i++) if (fs_cyc[i] - fs_cyc[i-1] != PERIOD) bad_gap++;
    checks++;
    if (fs_cyc.size() != 16 || bad_gap != 0) begin
      errors++;
      $display("FAIL random_frames: got %0d starts with %0d bad spacings, required 16 spaced %0d",
               fs_cyc.size(), bad_gap, PERIOD);
    end
  endtask

  task automatic test_tx_en_drop();
    int d;
    int n = 0;
    logic [DATA_W-1:0] w;
    clear_obs();
    for (int i = 0; i < 3; i++) begin
      w = DATA_W'($urandom);
      push_word(w);
      if (i == 0) add_exp(w);
    end
    tx_en = 1'b1;
    while (fs_cyc.size() == 0 && n < 50) begin
      step();
      n++;
    end
    tx_en = 1'b0;
    run_quiet(100, "txen");
    d = first_diff();
    checks++;
    if (d >= 0 || fs_cyc.size() != 1) begin
      errors++;
      $display("FAIL txen_frame: got %0d frames, first diff %0d, required 1 complete frame", fs_cyc.size(), d);
    end
    checks++;
    if (rm_cyc.size() != 1 || fifo.size() != 2) begin
      errors++;
      $display("FAIL txen_no_req: got %0d removes, %0d words left, required 1 and 2", rm_cyc.size(), fifo.size());
    end
    fifo.delete();
    empty = 1'b1;
  endtask

  task automatic test_timeout();
    clear_obs();
    drop_reads = 1;
    push_word(DATA_W'($urandom));
    tx_en = 1'b1;
    run_quiet(100, "timeout");
    tx_en = 1'b0;
    drop_reads = 0;
    checks++;
    if (rm_cyc.size() != 1 || to_cyc.size() != 1 || to_cyc[0] - rm_cyc[0] != 3) begin
      errors++;
      $display("FAIL timeout_pulse: got %0d removes, %0d pulses, required 1 pulse 3 cycles after remove",
               rm_cyc.size(), to_cyc.size());
    end
    checks++;
    if (to_cyc.size() != 1 || busy_hist[to_cyc[0]] !== 1'b1 || busy_hist[to_cyc[0] + 1] !== 1'b0) begin
      errors++;
      $display("FAIL timeout_idle: required busy high on pulse and low the next cycle");
    end
    checks++;
    if (obs_bits.size() != 0) begin
      errors++;
      $display("FAIL timeout_no_data: got %0d valid bits, required 0", obs_bits.size());
    end
  endtask

  task automatic test_flush();
    int d;
    int n = 0;
    logic [DATA_W-1:0] w1, w2;
    clear_obs();
    w1 = DATA_W'($urandom);
    w2 = DATA_W'($urandom);
    push_word(w1);
    push_word(w2);
    add_exp(w1);
    while (exp_bits.size() > 4) void'(exp_bits.pop_back());
    add_exp(w2);
    tx_en = 1'b1;
    while (obs_bits.size() < 4 && n < 60) begin
      step();
      n++;
    end
    sync_flush = 1'b1;
    tx_en      = 1'b0;
    step();
    sync_flush = 1'b0;
    checks++;
    if ({ser_valid, ser_out, busy, remove} !== 4'b0100) begin
      errors++;
      $display("FAIL flush_outputs: got sv/so/bz/rm=%b, required 0100", {ser_valid, ser_out, busy, remove});
    end
    for (int i = 0; i < 10; i++) step();
    checks++;
    if (rm_cyc.size() != 1) begin
      errors++;
      $display("FAIL flush_no_req: got %0d removes, required 1", rm_cyc.size());
    end
    tx_en = 1'b1;
    run_quiet(100, "flush");
    tx_en = 1'b0;
    d = first_diff();
    checks++;
    if (d >= 0) begin
      errors++;
      $display("FAIL flush_stream: differs at bit %0d, got %0d bits, required %0d", d, obs_bits.size(), exp_bits.size());
    end
  endtask

  task automatic test_reset_mid();
    int d;
    int n = 0;
    int rel;
    logic [DATA_W-1:0] w1, w2;
    clear_obs();
    w1 = DATA_W'($urandom);
    w2 = DATA_W'($urandom);
    push_word(w1);
    push_word(w2);
    add_exp(w1);
    while (exp_bits.size() > 3) void'(exp_bits.pop_back());
    add_exp(w2);
    tx_en = 1'b1;
    while (obs_bits.size() < 3 && n < 60) begin
      step();
      n++;
    end
    rst = 1'b0;
    step();
    checks++;
    if ({remove, ser_out, ser_valid, frame_start, busy, rd_timeout} !== 6'b010000) begin
      errors++;
      $display("FAIL midreset_outputs: got rm/so/sv/fs/bz/to=%b, required 010000",
               {remove, ser_out, ser_valid, frame_start, busy, rd_timeout});
    end
    step();
    rst = 1'b1;
    rel = cyc;
    run_quiet(100, "midreset");
    tx_en = 1'b0;
    checks++;
    if (rm_cyc.size() != 2 || rm_cyc[1] < rel + 1) begin
      errors++;
      $display("FAIL midreset_req: got %0d removes, required 2 with second at or after cycle %0d", rm_cyc.size(), rel + 1);
    end
    d = first_diff();
    checks++;
    if (d >= 0) begin
      errors++;
      $display("FAIL midreset_stream: differs at bit %0d, got %0d bits, required %0d", d, obs_bits.size(), exp_bits.size());
    end
  endtask

  task automatic test_remove_rule();
    checks++;
    if (underflow != 0 || bad_remove != 0) begin
      errors++;
      $display("FAIL remove_rule: got %0d removes on empty FIFO and %0d outside request, required 0 0",
               underflow, bad_remove);
    end
  endtask

  initial begin
    test_reset();
    test_known_word();
    test_back_to_back();
    test_random();
    test_tx_en_drop();
    test_timeout();
    test_flush();
    test_reset_mid();
    test_remove_rule();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_tx_ctrl.md
SERIAL_TX_CTRL -- requirements
Module: serial_tx_ctrl

Interface
REQ-001 Parameter DATA_W, default 8, width of one FIFO word and of one serial frame payload.
REQ-002 Parameter GAP, default 1, number of idle bit-times between frames (0 allowed).
REQ-003 Parameter MSB_FIRST, default 1; 1 = payload bit DATA_W-1 sent first, 0 = bit 0 first.
REQ-004 Clocking and reset: one clock; reset is synchronous and active-low.
REQ-005 clk_out  input  1  read-domain clock; all state updates on its rising edge.
REQ-006 rst  input  1  synchronous active-low reset.
REQ-007 empty  input  1  FIFO read-side empty flag.
REQ-008 rden  input  1  read-side strobe; rddata is valid in the same cycle that rden=1.
REQ-009 rddata  input  DATA_W  FIFO read data.
REQ-010 sync_flush  input  1  flush, already synchronised to clk_out.
REQ-011 tx_en  input  1  level enable; new frames start only while high.
REQ-012 remove  output  1  one-cycle read request to the FIFO read side.
REQ-013 ser_out  output  1  serial data line; idles at 1.
REQ-014 ser_valid  output  1  high while ser_out carries a payload or parity bit.
REQ-015 frame_start  output  1  pulses high with the first payload bit of each frame.
REQ-016 busy  output  1  high in every state except IDLE.
REQ-017 rd_timeout  output  1  one-cycle pulse when a requested word does not arrive.

Function
REQ-018 States: IDLE, REQ, WAIT, SHIFT, PAR, GAP; all outputs are registered.
REQ-019 IDLE -> REQ when tx_en=1 and empty=0; otherwise remain in IDLE.
REQ-020 REQ: remove=1 for exactly one cycle, then -> WAIT.
REQ-021 WAIT, rden=1: capture rddata into the shift register and a bit counter is loaded with DATA_W-1; -> SHIFT.
REQ-022 WAIT: if rden has not been seen within 3 cycles of entering WAIT, pulse rd_timeout, transfer no data, -> IDLE.
REQ-023 SHIFT: one payload bit per cycle, ser_valid=1, frame_start=1 only on the first bit; bit order per MSB_FIRST.
REQ-024 SHIFT exits after exactly DATA_W cycles: to PAR if parity is compiled in, else to GAP (or to IDLE when GAP=0).
REQ-025 GAP: ser_out=1, ser_valid=0 for exactly GAP cycles, then -> IDLE.
REQ-026 Back-to-back frames (tx_en=1, empty=0 throughout) have a period of DATA_W + GAP + 3 cycles (+1 with parity).
REQ-027 remove is never asserted outside REQ, and is never asserted while empty=1 at the REQ entry decision.
REQ-028 tx_en falling mid-frame does not abort the frame; the current frame completes and no new REQ is issued.
REQ-029 sync_flush=1 in any state: next cycle in IDLE with ser_out=1, ser_valid=0, remove=0 and the counters cleared; the partially sent frame is dropped.
REQ-030 sync_flush has priority over every other transition, including the REQ entry decision.
REQ-031 The bit counter width is $clog2(DATA_W) (minimum 1), it counts down, and it never wraps.

Reset
REQ-032 rst=0 at a clk_out edge: state=IDLE, remove=0, ser_out=1, ser_valid=0, frame_start=0, busy=0, rd_timeout=0, shift register and counters cleared.
REQ-033 Reset asserted mid-frame behaves as REQ-032 with no further bits emitted; the first REQ after release comes no earlier than 1 cycle after rst=1.

Configuration
REQ-034 Macro SERIAL_TX_PARITY_EN defined: state PAR emits one even-parity bit (XOR of the payload) with ser_valid=1 after the last payload bit.
REQ-035 SERIAL_TX_PARITY_EN undefined: PAR state and parity logic are absent, and SHIFT goes directly to GAP or IDLE.

Verification
REQ-036 DATA_W=8, MSB_FIRST=1, word 0xA5, rden one cycle after remove -> ser_out 1,0,1,0,0,1,0,1 on 8 consecutive cycles, frame_start on the first bit only.
REQ-037 Same word, SERIAL_TX_PARITY_EN defined -> 9th valid bit = 0; with word 0x07 -> parity bit = 1.
REQ-038 Two queued words 0x01 then 0x80, GAP=1, tx_en held high -> second frame_start exactly 12 cycles after the first (no parity).
REQ-039 remove issued but rden held 0 -> rd_timeout pulses on the 3rd WAIT cycle, state returns to IDLE, ser_valid stays 0.
REQ-040 sync_flush asserted on the 4th payload bit -> next cycle ser_valid=0, ser_out=1, busy=0, and no remove until empty=0 and tx_en=1 are seen again.
REQ-041 rst=0 driven during SHIFT, then released -> all outputs at REQ-032 values on the following edge, then normal frame resumes from the next FIFO word.
